// File: rtl/bdiv.sv
// Sequential signed divider: restoring shift/subtract on operand magnitudes,
// one quotient bit per cycle, sign fix-up in a final cycle.
module bdiv #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] dd,
    input  logic [n-1:0] dr,
    output logic [n-1:0] q,
    output logic [n-1:0] rem,
    output logic         busy,
    output logic         done,
    output logic         dbz
);
    localparam int CW = (n > 2) ? $clog2(n) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t         r_state, w_next;
    logic [n-1:0]   r_p;
    logic [n-1:0]   r_qw;
    logic [n-1:0]   r_mdr;
    logic [CW-1:0]  r_cnt;
    logic           r_sq, r_sr;
    logic [n-1:0]   r_q, r_rem;
    logic           r_busy, r_done, r_dbz;

    logic [n-1:0]   w_mdd, w_mdr;
    logic [n:0]     w_sh;
    logic [n-1:0]   w_t;
    logic           w_ge;

    assign w_mdd = dd[n-1] ? -dd : dd;
    assign w_mdr = dr[n-1] ? -dr : dr;

    // Partial remainder stays below |dr| <= 2^(n-1), so n bits hold it; only
    // the shifted value needs the extra bit for the compare.
    assign w_sh = {r_p, r_qw[n-1]};
    assign w_ge = (w_sh >= {1'b0, r_mdr});
    assign w_t  = w_sh[n-1:0] - r_mdr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = (dr == '0) ? DONE : RUN;
            RUN:  if (r_cnt == CW'(n-1)) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: if (!r_busy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // On the divide-by-zero path DONE is entered with busy still set; that
    // first DONE edge raises done, the second returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p    <= '0;
            r_qw   <= '0;
            r_mdr  <= '0;
            r_cnt  <= '0;
            r_sq   <= 1'b0;
            r_sr   <= 1'b0;
            r_q    <= '0;
            r_rem  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_p    <= '0;
                    r_qw   <= w_mdd;
                    r_mdr  <= w_mdr;
                    r_cnt  <= '0;
                    r_sq   <= dd[n-1] ^ dr[n-1];
                    r_sr   <= dd[n-1];
                    r_busy <= 1'b1;
                    if (dr == '0) begin
                        r_q   <= '1;
                        r_rem <= dd;
                        r_dbz <= 1'b1;
                    end
                end
                RUN: begin
                    r_p   <= w_ge ? w_t : w_sh[n-1:0];
                    r_qw  <= {r_qw[n-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: begin
                    r_q    <= r_sq ? -r_qw : r_qw;
                    r_rem  <= r_sr ? -r_p : r_p;
                    r_dbz  <= 1'b0;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                DONE: begin
                    if (r_busy) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_done <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q    = r_q;
    assign rem  = r_rem;
    assign busy = r_busy;
    assign done = r_done;
    assign dbz  = r_dbz;
endmodule
